return_axi_writer: RTL and testbench

RETURN_AXI_WRITER -- requirements
Module: return_axi_writer

---
 rtl/return_axi_writer_pkg.sv | 26 ++
 rtl/return_axi_writer_burst_len_calc.sv | 24 ++
 rtl/return_axi_writer.sv | 141 ++++++++++++++
 tb/tb_return_axi_writer.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/return_axi_writer_pkg.sv
// Shared AXI constants, state encoding and a small min helper for the return writer.
package return_axi_writer_pkg;

  localparam logic [2:0] AWSIZE_64B = 3'd6;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [3:0] CACHE_DEF  = 4'b0011;
  localparam logic [1:0] RESP_OKAY  = 2'b00;

  // Burst length counter width: holds 1..256 beats.
  localparam int LEN_W      = 9;
  localparam int BEAT_SHIFT = 6;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_AW   = 3'd1;
  localparam state_t ST_W    = 3'd2;
  localparam state_t ST_B    = 3'd3;
  localparam state_t ST_FIN  = 3'd4;

  function automatic logic [LEN_W-1:0] min_len(input logic [LEN_W-1:0] a,
                                                input logic [LEN_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/return_axi_writer_burst_len_calc.sv
// Combinational burst sizing: min of remaining beats, MAX_BURST and beats left in the 4 KB page.
module return_axi_writer_burst_len_calc
  import return_axi_writer_pkg::*;
#(
  parameter int MAX_BURST = 16
) (
  input  logic [5:0]       beat_idx,
  input  logic [15:0]      remaining,
  output logic [LEN_W-1:0] len
);

  logic [6:0]       headroom_raw;
  logic [LEN_W-1:0] headroom;
  logic [LEN_W-1:0] rem_clip;

  always_comb begin
    // A 4 KB page holds 64 beats of 64 bytes; beat_idx is the beat slot inside the page.
    headroom_raw = 7'd64 - {1'b0, beat_idx};
    headroom     = LEN_W'(headroom_raw);
    rem_clip     = (remaining > 16'(MAX_BURST)) ? LEN_W'(MAX_BURST) : LEN_W'(remaining);
    len          = min_len(rem_clip, headroom);
  end

endmodule

// File: rtl/return_axi_writer.sv
// Writes a counted stream of 64-byte beats to memory as 4 KB-safe AXI INCR bursts, one burst in flight.
module return_axi_writer
  import return_axi_writer_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 512,
  parameter int MAX_BURST = 16
) (
  input  logic                system_clk,
  input  logic                rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   return_addr,
  input  logic [15:0]         return_patch_num,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [ADDR_W-1:0]   m_axi_awaddr,
  output logic [7:0]          m_axi_awlen,
  output logic [2:0]          m_axi_awsize,
  output logic [1:0]          m_axi_awburst,
  output logic                m_axi_awlock,
  output logic [3:0]          m_axi_awcache,
  output logic [2:0]          m_axi_awprot,
  output logic                m_axi_awvalid,
  input  logic                m_axi_awready,
  output logic [DATA_W-1:0]   m_axi_wdata,
  output logic [DATA_W/8-1:0] m_axi_wstrb,
  output logic                m_axi_wlast,
  output logic                m_axi_wvalid,
  input  logic                m_axi_wready,
  input  logic [1:0]          m_axi_bresp,
  input  logic                m_axi_bvalid,
  output logic                m_axi_bready,
  output logic                busy,
  output logic                done,
  output logic                error
);

  state_t             state_reg;
  logic [ADDR_W-1:0]  addr_reg;
  logic [15:0]        remaining_reg;
  logic [LEN_W-1:0]   burst_len_reg;
  logic [LEN_W-1:0]   beat_cnt_reg;
  logic               error_reg;

  logic [LEN_W-1:0]   calc_len;
  logic               w_fire;
  logic               last_beat;
  logic [15:0]        remaining_after;
  logic [ADDR_W-1:0]  addr_after;

  return_axi_writer_burst_len_calc #(
    .MAX_BURST (MAX_BURST)
  ) u_burst_len_calc (
    .beat_idx  (addr_reg[11:6]),
    .remaining (remaining_reg),
    .len       (calc_len)
  );

  assign last_beat       = (beat_cnt_reg == (burst_len_reg - LEN_W'(1)));
  assign w_fire          = (state_reg == ST_W) && in_valid && m_axi_wready;
  assign remaining_after = remaining_reg - 16'(burst_len_reg);
  assign addr_after      = addr_reg + (ADDR_W'(burst_len_reg) << BEAT_SHIFT);

  always_ff @(posedge system_clk) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      addr_reg      <= '0;
      remaining_reg <= '0;
      burst_len_reg <= '0;
      beat_cnt_reg  <= '0;
      error_reg     <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            addr_reg      <= return_addr;
            remaining_reg <= return_patch_num;
            error_reg     <= 1'b0;
            state_reg     <= (return_patch_num == 16'd0) ? ST_FIN : ST_AW;
          end
        end
        ST_AW: begin
          // awlen is driven from calc_len, which only depends on registers frozen during AW.
          if (m_axi_awready) begin
            burst_len_reg <= calc_len;
            beat_cnt_reg  <= '0;
            state_reg     <= ST_W;
          end
        end
        ST_W: begin
          if (w_fire) begin
            beat_cnt_reg <= beat_cnt_reg + LEN_W'(1);
            if (last_beat) begin
              state_reg <= ST_B;
            end
          end
        end
        ST_B: begin
          if (m_axi_bvalid) begin
            remaining_reg <= remaining_after;
            addr_reg      <= addr_after;
            if (m_axi_bresp != RESP_OKAY) begin
              error_reg <= 1'b1;
            end
            state_reg <= (remaining_after != 16'd0) ? ST_AW : ST_FIN;
          end
        end
        ST_FIN: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_axi_awaddr  = addr_reg;
  assign m_axi_awlen   = 8'(calc_len - LEN_W'(1));
  assign m_axi_awsize  = AWSIZE_64B;
  assign m_axi_awburst = BURST_INCR;
  assign m_axi_awlock  = 1'b0;
  assign m_axi_awcache = CACHE_DEF;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_awvalid = (state_reg == ST_AW);

  // The write channel is a straight pass-through of the result stream while in W.
  assign m_axi_wdata   = in_data;
  assign m_axi_wstrb   = '1;
  assign m_axi_wvalid  = (state_reg == ST_W) && in_valid;
  assign m_axi_wlast   = (state_reg == ST_W) && last_beat;
  assign in_ready      = (state_reg == ST_W) && m_axi_wready;

  assign m_axi_bready  = (state_reg == ST_B);

  assign busy          = (state_reg != ST_IDLE);
  assign done          = (state_reg == ST_FIN);
  assign error         = error_reg;

endmodule

// File: tb/tb_return_axi_writer.sv
// Directed bench for return_axi_writer: AXI slave model logs bursts and beats, checks against hand values.
module tb_return_axi_writer;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 512;
  localparam int MAX_BURST = 16;

  logic                system_clk = 1'b0;
  logic                rst = 1'b1;
  logic                start = 1'b0;
  logic [ADDR_W-1:0]   return_addr = '0;
  logic [15:0]         return_patch_num = '0;
  logic [DATA_W-1:0]   in_data = '0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [ADDR_W-1:0]   m_axi_awaddr;
  logic [7:0]          m_axi_awlen;
  logic [2:0]          m_axi_awsize;
  logic [1:0]          m_axi_awburst;
  logic                m_axi_awlock;
  logic [3:0]          m_axi_awcache;
  logic [2:0]          m_axi_awprot;
  logic                m_axi_awvalid;
  logic                m_axi_awready = 1'b0;
  logic [DATA_W-1:0]   m_axi_wdata;
  logic [DATA_W/8-1:0] m_axi_wstrb;
  logic                m_axi_wlast;
  logic                m_axi_wvalid;
  logic                m_axi_wready = 1'b0;
  logic [1:0]          m_axi_bresp = 2'b00;
  logic                m_axi_bvalid = 1'b0;
  logic                m_axi_bready;
  logic                busy;
  logic                done;
  logic                error;

  return_axi_writer #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .system_clk       (system_clk),
    .rst              (rst),
    .start            (start),
    .return_addr      (return_addr),
    .return_patch_num (return_patch_num),
    .in_data          (in_data),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .m_axi_awaddr     (m_axi_awaddr),
    .m_axi_awlen      (m_axi_awlen),
    .m_axi_awsize     (m_axi_awsize),
    .m_axi_awburst    (m_axi_awburst),
    .m_axi_awlock     (m_axi_awlock),
    .m_axi_awcache    (m_axi_awcache),
    .m_axi_awprot     (m_axi_awprot),
    .m_axi_awvalid    (m_axi_awvalid),
    .m_axi_awready    (m_axi_awready),
    .m_axi_wdata      (m_axi_wdata),
    .m_axi_wstrb      (m_axi_wstrb),
    .m_axi_wlast      (m_axi_wlast),
    .m_axi_wvalid     (m_axi_wvalid),
    .m_axi_wready     (m_axi_wready),
    .m_axi_bresp      (m_axi_bresp),
    .m_axi_bvalid     (m_axi_bvalid),
    .m_axi_bready     (m_axi_bready),
    .busy             (busy),
    .done             (done),
    .error            (error)
  );

  always #5 system_clk = ~system_clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [DATA_W-1:0] pattern(input int i);
    logic [31:0] w;
    w = (32'(i) * 32'h9E37_79B9) ^ 32'h1234_5678;
    return {16{w}};
  endfunction

  // Controls written only by the stimulus process.
  bit gap = 1'b0;
  int err_burst = -1;
  int run_id = 0;

  // Slave-model state written only by the slave process.
  int              seen_id = 0;
  int              aw_cnt, n_beats, w_idx, w_len, src_idx, b_num;
  int              wlast_err, data_err, cross_err, overlap_err, done_count, done_after_b;
  bit              b_pending, b_prev, b_taken;
  logic [31:0]     w_base;
  logic [31:0]     aw_addr [8];
  logic [7:0]      aw_len [8];
  logic [31:0]     beat_addr [64];
  logic [DATA_W-1:0] beat_data [64];

  // Inputs change on the falling edge; handshakes are sampled 1 time unit later and hold to the next rise.
  always @(negedge system_clk) begin
    if (rst) begin
      b_pending     = 1'b0;
      m_axi_bvalid  = 1'b0;
      m_axi_awready = 1'b0;
      m_axi_wready  = 1'b0;
      in_valid      = 1'b0;
    end else begin
      m_axi_awready = gap ? ($urandom_range(0, 1) == 1) : 1'b1;
      m_axi_wready  = gap ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_valid      = gap ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_data       = pattern(src_idx);
      m_axi_bvalid  = b_pending;
      m_axi_bresp   = (b_pending && b_num == err_burst) ? 2'd2 : 2'd0;
    end
    #1;
    if (run_id != seen_id) begin
      seen_id = run_id;
      aw_cnt = 0; n_beats = 0; w_idx = 0; w_len = 0; src_idx = 0; b_num = 0;
      wlast_err = 0; data_err = 0; cross_err = 0; overlap_err = 0;
      done_count = 0; done_after_b = 0; b_prev = 1'b0;
    end
    b_taken = 1'b0;
    if (rst) begin
      b_prev = 1'b0;
    end else begin
      if (m_axi_awvalid && m_axi_wvalid) overlap_err++;
      if (m_axi_awvalid && m_axi_awready) begin
        if (aw_cnt < 8) begin
          aw_addr[aw_cnt] = m_axi_awaddr;
          aw_len[aw_cnt]  = m_axi_awlen;
        end
        aw_cnt++;
        w_base = m_axi_awaddr;
        w_len  = int'(m_axi_awlen) + 1;
        w_idx  = 0;
        if (int'(m_axi_awaddr[11:0]) + w_len * 64 > 4096) cross_err++;
      end
      if (m_axi_wvalid && m_axi_wready) begin
        if (m_axi_wlast != (w_idx == w_len - 1)) wlast_err++;
        if (m_axi_wdata != pattern(src_idx)) data_err++;
        if (n_beats < 64) begin
          beat_addr[n_beats] = w_base + 32'(w_idx) * 32'd64;
          beat_data[n_beats] = m_axi_wdata;
        end
        if (m_axi_wlast) b_pending = 1'b1;
        n_beats++; w_idx++; src_idx++;
      end
      if (m_axi_bvalid && m_axi_bready) begin
        b_pending = 1'b0;
        b_num++;
        b_taken = 1'b1;
      end
      if (done) begin
        done_count++;
        if (b_prev) done_after_b++;
      end
      b_prev = b_taken;
    end
  end

  function automatic int mem_errors(input logic [31:0] base);
    int n = 0;
    for (int i = 0; i < n_beats && i < 64; i++) begin
      if (beat_addr[i] != base + 32'(i) * 32'd64) n++;
      if (beat_data[i] != pattern(i)) n++;
    end
    return n;
  endfunction

  task automatic run(input logic [31:0] addr, input logic [15:0] num, input bit glitch);
    @(negedge system_clk);
    run_id++;
    return_addr      = addr;
    return_patch_num = num;
    start            = 1'b1;
    @(negedge system_clk);
    start = 1'b0;
    if (glitch) begin
      repeat (6) @(negedge system_clk);
      return_addr      = 32'hDEAD_0000;
      return_patch_num = 16'd3;
      start            = 1'b1;
      @(negedge system_clk);
      start = 1'b0;
    end
    for (int i = 0; i < 3000; i++) begin
      @(negedge system_clk);
      if (done_count != 0) break;
    end
    repeat (2) @(negedge system_clk);
    #2;
    $display("run addr=%08h num=%0d bursts=%0d beats=%0d done=%0d", addr, num, aw_cnt, n_beats, done_count);
  endtask

  initial begin
    rst = 1'b1;
    repeat (3) @(posedge system_clk);
    #1;
    check("reset_outputs", {56'd0, m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready,
                            in_ready, busy, done, error}, 64'd0);
    check("const_aw", {51'd0, m_axi_awsize, m_axi_awburst, m_axi_awlock, m_axi_awcache, m_axi_awprot},
          {51'd0, 3'd6, 2'b01, 1'b0, 4'b0011, 3'b000});
    check("wstrb_ones", 64'(&m_axi_wstrb), 64'd1);
    @(negedge system_clk);
    rst = 1'b0;

    // Two bursts 16+4, with a start pulse while busy that must be ignored.
    run(32'h1000_0000, 16'd20, 1'b1);
    check("t35_done", done_count, 1);
    check("t35_aw_cnt", aw_cnt, 2);
    check("t35_aw0_addr", aw_addr[0], 32'h1000_0000);
    check("t35_aw0_len", aw_len[0], 8'd15);
    check("t35_aw1_addr", aw_addr[1], 32'h1000_0400);
    check("t35_aw1_len", aw_len[1], 8'd3);
    check("t35_beats", n_beats, 20);
    check("t35_wlast", wlast_err, 0);
    check("t35_mem", mem_errors(32'h1000_0000), 0);
    check("t35_done_after_b", done_after_b, 1);
    check("t35_overlap", overlap_err, 0);
    check("t35_error", error, 0);
    check("t35_busy_idle", busy, 0);

    // 4 KB boundary split.
    run(32'h0000_0F80, 16'd4, 1'b0);
    check("t36_aw_cnt", aw_cnt, 2);
    check("t36_aw0_addr", aw_addr[0], 32'h0000_0F80);
    check("t36_aw0_len", aw_len[0], 8'd1);
    check("t36_aw1_addr", aw_addr[1], 32'h0000_1000);
    check("t36_aw1_len", aw_len[1], 8'd1);
    check("t36_cross", cross_err, 0);
    check("t36_mem", mem_errors(32'h0000_0F80), 0);

    // Zero-length task: done in the cycle after start, no address phase.
    @(negedge system_clk);
    run_id++;
    return_addr      = 32'h0000_8000;
    return_patch_num = 16'd0;
    start            = 1'b1;
    @(posedge system_clk);
    #1;
    check("t37_done_pulse", done, 1);
    @(negedge system_clk);
    start = 1'b0;
    @(posedge system_clk);
    #1;
    check("t37_done_low", done, 0);
    repeat (3) @(negedge system_clk);
    #2;
    check("t37_aw_cnt", aw_cnt, 0);
    check("t37_done_cnt", done_count, 1);

    // SLVERR on the first burst: sticky error, second burst still issued.
    err_burst = 0;
    run(32'h2000_0000, 16'd32, 1'b0);
    check("t38_done", done_count, 1);
    check("t38_aw_cnt", aw_cnt, 2);
    check("t38_aw1_addr", aw_addr[1], 32'h2000_0400);
    check("t38_error_sticky", error, 1);
    err_burst = -1;
    run(32'h3000_0000, 16'd2, 1'b0);
    check("t38_error_cleared", error, 0);
    check("t38_next_done", done_count, 1);

    // Random ready/valid gaps on both sides of the write channel.
    gap = 1'b1;
    run(32'h4000_0000, 16'd16, 1'b0);
    check("t39_done", done_count, 1);
    check("t39_aw_cnt", aw_cnt, 1);
    check("t39_aw0_len", aw_len[0], 8'd15);
    check("t39_beats", n_beats, 16);
    check("t39_wlast", wlast_err, 0);
    check("t39_data", data_err, 0);
    check("t39_mem", mem_errors(32'h4000_0000), 0);

    // Reset during the second burst's data phase, with error already set by the first.
    err_burst = 0;
    @(negedge system_clk);
    run_id++;
    return_addr      = 32'h6000_0000;
    return_patch_num = 16'd32;
    start            = 1'b1;
    @(negedge system_clk);
    start = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge system_clk);
      if (n_beats >= 19) break;
    end
    check("t40_reached_w", 64'(n_beats >= 19), 64'd1);
    check("t40_error_pre", error, 1);
    @(negedge system_clk);
    rst = 1'b1;
    @(posedge system_clk);
    #1;
    check("t40_reset_outputs", {56'd0, m_axi_awvalid, m_axi_wvalid, m_axi_wlast, m_axi_bready,
                                in_ready, busy, done, error}, 64'd0);
    @(negedge system_clk);
    rst = 1'b0;
    gap = 1'b0;
    err_burst = -1;
    run(32'h5000_0000, 16'd4, 1'b0);
    check("t40_after_done", done_count, 1);
    check("t40_after_aw", aw_cnt, 1);
    check("t40_after_len", aw_len[0], 8'd3);
    check("t40_after_mem", mem_errors(32'h5000_0000), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
